// File: rtl/multicycle_ctrl_if.sv
// Handshake bundle between the multicycle sequencer and the datapath/decoder.
// The master side is the sequencer; the slave side is whatever drives decoder/memory status.
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic        regw;
    logic        ramR;
    logic        ramW;
    logic        imem_ready;
    logic        dmem_ready;
    logic        ir_load;
    logic        pc_en;
    logic        regw_en;
    logic        ram_rd;
    logic        ram_wr;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] instret;

    modport master (
        input  opcode, regw, ramR, ramW, imem_ready, dmem_ready,
        output ir_load, pc_en, regw_en, ram_rd, ram_wr, state, fault, instret
    );

    modport slave (
        output opcode, regw, ramR, ramW, imem_ready, dmem_ready,
        input  ir_load, pc_en, regw_en, ram_rd, ram_wr, state, fault, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer: turns decoder level controls into
// single-cycle strobes, waits on memory, traps illegal opcodes and memory timeouts.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               nreset,
    multicycle_ctrl_if.master  bus
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LIMIT = CW'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_t;

    state_t         state_q, state_d;
    logic           fault_q, fault_d;
    logic [31:0]    instret_q, instret_d;
    logic [CW-1:0]  tmo_q, tmo_d, tmo_inc;

    logic ir_load, pc_en, regw_en, ram_rd, ram_wr;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b0110111, 7'b0010111,
            7'b1100111, 7'b1100011, 7'b1101111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        instret_d = instret_q;
        tmo_d     = tmo_q;
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        regw_en   = 1'b0;
        ram_rd    = 1'b0;
        ram_wr    = 1'b0;
        tmo_inc   = (tmo_q == '1) ? tmo_q : tmo_q + CW'(1);

        case (state_q)
            FETCH: begin
                ir_load = bus.imem_ready;
                if (bus.imem_ready) state_d = DECODE;
            end
            DECODE: begin
                state_d = is_legal(bus.opcode) ? EXEC : HALT;
            end
            EXEC: begin
                if (bus.ramR && bus.ramW) begin
                    state_d = HALT;
                end else if (bus.ramR || bus.ramW) begin
                    state_d = MEM;
                    tmo_d   = '0;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                ram_rd = bus.ramR;
                ram_wr = bus.ramW;
                if (bus.dmem_ready) begin
                    // A store has nothing to write back, so it retires here.
                    if (bus.ramW) begin
                        pc_en     = 1'b1;
                        instret_d = instret_q + 32'd1;
                        state_d   = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if ((MEM_TIMEOUT != 0) && (tmo_inc == TMO_LIMIT)) state_d = HALT;
                end
            end
            WB: begin
                regw_en   = bus.regw;
                pc_en     = 1'b1;
                instret_d = instret_q + 32'd1;
                state_d   = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase

        if (state_d == HALT) fault_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q   <= FETCH;
            fault_q   <= 1'b0;
            instret_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.ir_load = ir_load;
    assign bus.pc_en   = pc_en;
    assign bus.regw_en = regw_en;
    assign bus.ram_rd  = ram_rd;
    assign bus.ram_wr  = ram_wr;
    assign bus.state   = state_q;
    assign bus.fault   = fault_q;
    assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a vector table for the common instruction flows
// plus hand-written sequences for timeouts, halting, reset in MEM and instret wrap.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b0000000;

    typedef struct {
        logic        nreset;
        logic [6:0]  opcode;
        logic        regw;
        logic        ramR;
        logic        ramW;
        logic        imem;
        logic        dmem;
        logic [2:0]  st;
        logic        ir_load;
        logic        pc_en;
        logic        regw_en;
        logic        ram_rd;
        logic        ram_wr;
        logic        fault;
        logic [31:0] instret;
    } vec_t;

    logic clock;
    logic nreset;
    int   num_checks;
    int   num_fails;
    vec_t vecs[$];

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic nr, input logic [6:0] op, input logic rw, input logic rr, input logic ww,
        input logic im, input logic dm, input logic [2:0] st, input logic il, input logic pc,
        input logic re, input logic rd, input logic wr, input logic ft, input logic [31:0] ir);
        vec_t v;
        v.nreset = nr; v.opcode = op; v.regw = rw; v.ramR = rr; v.ramW = ww;
        v.imem = im; v.dmem = dm; v.st = st; v.ir_load = il; v.pc_en = pc;
        v.regw_en = re; v.ram_rd = rd; v.ram_wr = wr; v.fault = ft; v.instret = ir;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic nr, input logic [6:0] op, input logic rw, input logic rr,
                         input logic ww, input logic im, input logic dm);
        nreset         = nr;
        bus.opcode     = op;
        bus.regw       = rw;
        bus.ramR       = rr;
        bus.ramW       = ww;
        bus.imem_ready = im;
        bus.dmem_ready = dm;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        drive(v.nreset, v.opcode, v.regw, v.ramR, v.ramW, v.imem, v.dmem);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkField($sformatf("row%0d state", idx),   32'(bus.state),   32'(v.st));
        checkField($sformatf("row%0d ir_load", idx), 32'(bus.ir_load), 32'(v.ir_load));
        checkField($sformatf("row%0d pc_en", idx),   32'(bus.pc_en),   32'(v.pc_en));
        checkField($sformatf("row%0d regw_en", idx), 32'(bus.regw_en), 32'(v.regw_en));
        checkField($sformatf("row%0d ram_rd", idx),  32'(bus.ram_rd),  32'(v.ram_rd));
        checkField($sformatf("row%0d ram_wr", idx),  32'(bus.ram_wr),  32'(v.ram_wr));
        checkField($sformatf("row%0d fault", idx),   32'(bus.fault),   32'(v.fault));
        checkField($sformatf("row%0d instret", idx), bus.instret,      v.instret);
    endtask

    // Two reset edges; returns at a negedge with nreset released and the FSM in FETCH.
    task automatic doReset();
        @(negedge clock);
        drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        nreset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rd_cycles;
        logic halted;
        logic any_strobe;

        num_checks = 0;
        num_fails  = 0;
        drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //            nr  opcode  rw rr ww im dm   st il pc re rd wr ft instret
        vecs.push_back(mk(1, OP_ADD, 1, 0, 0, 1, 1, 3'd0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, OP_ADD, 1, 0, 0, 1, 1, 3'd1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, OP_ADD, 1, 0, 0, 1, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, OP_ADD, 1, 0, 0, 1, 1, 3'd4, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, OP_ADD, 1, 0, 0, 0, 1, 3'd0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, OP_LW,  1, 1, 0, 1, 0, 3'd0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, OP_LW,  1, 1, 0, 1, 0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, OP_LW,  1, 1, 0, 1, 0, 3'd2, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, OP_LW,  1, 1, 0, 1, 0, 3'd3, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, OP_LW,  1, 1, 0, 1, 0, 3'd3, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, OP_LW,  1, 1, 0, 1, 0, 3'd3, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, OP_LW,  1, 1, 0, 1, 1, 3'd3, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, OP_LW,  1, 1, 0, 1, 1, 3'd4, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, OP_SW,  0, 0, 1, 1, 1, 3'd0, 1, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, OP_SW,  0, 0, 1, 1, 1, 3'd1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, OP_SW,  0, 0, 1, 1, 1, 3'd2, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, OP_SW,  0, 0, 1, 1, 1, 3'd3, 0, 1, 0, 0, 1, 0, 2));
        vecs.push_back(mk(1, OP_JAL, 1, 0, 0, 1, 1, 3'd0, 1, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(1, OP_JAL, 1, 0, 0, 1, 1, 3'd1, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(1, OP_JAL, 1, 0, 0, 1, 1, 3'd2, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(1, OP_JAL, 1, 0, 0, 1, 1, 3'd4, 0, 1, 1, 0, 0, 0, 3));
        vecs.push_back(mk(1, OP_BR,  0, 0, 0, 1, 1, 3'd0, 1, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk(1, OP_BR,  0, 0, 0, 1, 1, 3'd1, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk(1, OP_BR,  0, 0, 0, 1, 1, 3'd2, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk(1, OP_BR,  0, 0, 0, 1, 1, 3'd4, 0, 1, 0, 0, 0, 0, 4));
        vecs.push_back(mk(1, OP_BAD, 0, 0, 0, 1, 1, 3'd0, 1, 0, 0, 0, 0, 0, 5));
        vecs.push_back(mk(1, OP_BAD, 0, 0, 0, 1, 1, 3'd1, 0, 0, 0, 0, 0, 0, 5));
        vecs.push_back(mk(1, OP_BAD, 1, 1, 0, 1, 1, 3'd7, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(1, OP_BAD, 1, 1, 0, 1, 1, 3'd7, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(0, OP_BAD, 1, 1, 0, 1, 1, 3'd7, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(1, OP_ADD, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0));

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Illegal opcode: HALT holds with every strobe low despite active inputs.
        doReset();
        drive(1'b1, OP_BAD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        drive(1'b1, OP_BAD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); #1;
            any_strobe = bus.ir_load | bus.pc_en | bus.regw_en | bus.ram_rd | bus.ram_wr;
            checkField($sformatf("halt%0d strobes", i), 32'(any_strobe), 32'd0);
            checkField($sformatf("halt%0d state", i), 32'(bus.state), 32'd7);
        end
        checkField("halt fault", 32'(bus.fault), 32'd1);
        nreset = 1'b0;
        @(negedge clock);
        nreset = 1'b1;
        #1;
        checkField("halt reset state", 32'(bus.state), 32'd0);
        checkField("halt reset fault", 32'(bus.fault), 32'd0);

        // Load with dmem_ready stuck low runs into the 15-cycle timeout.
        doReset();
        drive(1'b1, OP_LW, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        rd_cycles = 0;
        halted    = 1'b0;
        for (int i = 0; i < 60 && !halted; i++) begin
            @(negedge clock); #1;
            if (bus.ram_rd) rd_cycles++;
            if (bus.state == 3'd7) halted = 1'b1;
        end
        checkField("timeout reached halt", 32'(halted), 32'd1);
        checkField("timeout ram_rd cycles", 32'(rd_cycles), 32'd15);
        checkField("timeout fault", 32'(bus.fault), 32'd1);
        checkField("timeout instret", bus.instret, 32'd0);

        // Both RAM requests in EXEC is a fault.
        doReset();
        drive(1'b1, OP_LW, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        @(negedge clock); #1;
        checkField("rdwr exec state", 32'(bus.state), 32'd2);
        @(negedge clock); #1;
        checkField("rdwr halt state", 32'(bus.state), 32'd7);
        checkField("rdwr fault", 32'(bus.fault), 32'd1);
        checkField("rdwr ram_rd", 32'(bus.ram_rd), 32'd0);

        // Reset during a pending store abandons the access.
        doReset();
        drive(1'b1, OP_SW, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock); #1;
        checkField("rstmem state", 32'(bus.state), 32'd3);
        checkField("rstmem ram_wr before", 32'(bus.ram_wr), 32'd1);
        nreset = 1'b0;
        @(negedge clock); #1;
        checkField("rstmem state after", 32'(bus.state), 32'd0);
        checkField("rstmem ram_wr after", 32'(bus.ram_wr), 32'd0);
        checkField("rstmem instret", bus.instret, 32'd0);

        // instret wraps when a branch retires at FFFFFFFF.
        doReset();
        drive(1'b1, OP_BR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        force dut.instret_q = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut.instret_q;
        #1;
        checkField("wrap preload", bus.instret, 32'hFFFF_FFFF);
        bus.imem_ready = 1'b1;
        #1;
        checkField("wrap fetch regw_en", 32'(bus.regw_en), 32'd0);
        @(negedge clock); #1;
        @(negedge clock); #1;
        @(negedge clock); #1;
        checkField("wrap wb state", 32'(bus.state), 32'd4);
        checkField("wrap wb pc_en", 32'(bus.pc_en), 32'd1);
        checkField("wrap wb regw_en", 32'(bus.regw_en), 32'd0);
        @(negedge clock); #1;
        checkField("wrap instret", bus.instret, 32'd0);
        checkField("wrap state", 32'(bus.state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the RISC-V core: walks each instruction through fetch, decode, execute, memory and writeback states. It turns the decoder's level-type controls (`regw`, `ramR`, `ramW`) into single-cycle strobes for the register file and RAM, and handles memory wait states. It sits between the decoder and the PC/IR/register-file/RAM enables, traps illegal opcodes and memory timeouts, and counts retired instructions.

## Interface
- `MEM_TIMEOUT`, default 15: maximum consecutive MEM cycles without `dmem_ready` before a fault; 0 disables the timeout.
- `clock`  in  1  single clock; everything is updated on the rising edge.
- `nreset`  in  1  synchronous, active-low reset.
- `opcode`  in  7  opcode field of the instruction register.
- `regw`  in  1  decoder register-write request.
- `ramR`  in  1  decoder RAM-read request.
- `ramW`  in  1  decoder RAM-write request.
- `imem_ready`  in  1  instruction word is valid this cycle.
- `dmem_ready`  in  1  data RAM has completed the access this cycle.
- `ir_load`  out  1  load the instruction register.
- `pc_en`  out  1  update the PC; the PC mux selects the source via the decoder's `pcsel`.
- `regw_en`  out  1  register-file write strobe.
- `ram_rd`  out  1  data RAM read request.
- `ram_wr`  out  1  data RAM write request.
- `state`  out  3  current state encoding.
- `fault`  out  1  sticky fault flag.
- `instret`  out  32  count of retired instructions.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Codes 5 and 6 are unused and go to HALT with `fault`=1.
- **FETCH**
  - `ir_load` = `imem_ready`.
  - Stays in FETCH while `imem_ready`=0; goes to DECODE when `imem_ready`=1.
- **DECODE** (one cycle)
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 0110111, 0010111, 1100111, 1100011, 1101111.
  - Legal opcode: go to EXEC. Any other opcode: go to HALT and set `fault`.
- **EXEC** (one cycle)
  - `ramR`&`ramW` both set: go to HALT with `fault`.
  - Exactly one of `ramR`/`ramW` set: go to MEM and clear the timeout counter.
  - Neither set: go to WB.
- **MEM**
  - `ram_rd`=`ramR` and `ram_wr`=`ramW`, held every cycle until `dmem_ready`.
  - `dmem_ready`=1 on a load: go to WB.
  - `dmem_ready`=1 on a store: the store retires in that cycle (`pc_en`=1, `instret`+1) and the FSM goes to FETCH.
  - `dmem_ready`=0: timeout counter increments. When it reaches `MEM_TIMEOUT` (nonzero), go to HALT with `fault`.
  - Counter width is clog2(`MEM_TIMEOUT`+1) and it saturates.
- **WB** (one cycle)
  - `regw_en`=`regw`, `pc_en`=1, `instret`+1, then go to FETCH.
  - Branches pass through WB with `regw`=0, so `regw_en` stays 0.
- **HALT**
  - All strobes 0; remains in HALT until reset.
- Strobes are decoded combinationally from the registered state plus `imem_ready`, `dmem_ready`, `regw`, `ramR`, `ramW`. In every other state all strobes are 0.
- `instret` is 32-bit and wraps FFFFFFFF→0. It never increments in HALT.
- `fault` is set on entry to HALT and cleared only by reset.

## Timing
- Reset: while `nreset`=0 at a clock edge, the FSM goes to FETCH and `instret`=0, `fault`=0, timeout counter=0. From the next cycle, `regw_en`, `ram_rd`, `ram_wr` and `pc_en` are 0, and `ir_load` follows `imem_ready` in FETCH.
- Reset during MEM abandons the access: `ram_rd`/`ram_wr` drop after the reset edge, and the store does not retire.
- Latency with both ready inputs held high:
  - ALU, U-type, jump and branch: 4 cycles (F, D, E, W).
  - Load: 5 cycles (F, D, E, M, W).
  - Store: 4 cycles (F, D, E, M).
  - Each cycle of `imem_ready`=0 or `dmem_ready`=0 adds one cycle.
- Exactly one `pc_en` pulse and one `instret` increment per retired instruction.
- Exactly one `regw_en` pulse per register-writing instruction.
- The RAM handshake completes in the cycle where `ram_rd` or `ram_wr` and `dmem_ready` are both high. The controller does not deassert a request before `dmem_ready`.
- `dmem_ready` outside MEM, or `imem_ready` outside FETCH: ignored.

## Test plan
- Reset, then `add` (0110011, `regw`=1) with both ready inputs high: states 0,1,2,4,0. `regw_en`=1 only in the WB cycle, `pc_en`=1 in the same cycle, `instret` goes 0→1.
- `lw` (0000011) with `dmem_ready` low for 3 MEM cycles: `ram_rd` high for 4 cycles, then WB with `regw_en`=1. Total 8 cycles; `instret`=1.
- `sw` (0100011) with `dmem_ready` immediate: `ram_wr` high 1 cycle, `pc_en` in the same cycle, return to FETCH. `regw_en` never asserts.
- Illegal opcode 0000000 in DECODE: `state`=7 and `fault`=1 next cycle. Strobes stay 0 for 20 cycles; `nreset`=0 for one edge returns `state`=0, `fault`=0.
- Load with `dmem_ready` stuck low and `MEM_TIMEOUT`=15: `ram_rd` is held 15 cycles, then HALT with `fault`=1.
- Preload `instret` to FFFFFFFF via force, retire one branch (1100011): `instret`=0 and `regw_en` stays 0.
